exe_unit_w1: RTL and testbench
==============================

// Module: exe_unit_w1
// PURPOSE
//   Registered signed ALU execution unit. It performs one of four operations on
//   two signed operands each clock cycle and registers the result plus four flags.
//   It is the datapath core of the execution stage: a sequencer drives it and
//   downstream logic samples o_result/o_status.
// PARAMETERS
//   m  default 4  operand/result width in bits (two's complement), m >= 2
//   n  default 2  opcode width in bits, n >= 2; only codes 0..3 are defined
// PORTS
//   i_clk     in   1    clock; all state updates on rising edge
//   i_rsn     in   1    reset, synchronous, active-low
//   i_oper    in   n    opcode
//   i_argA    in   m    operand A, signed
//   i_argB    in   m    operand B, signed
//   o_result  out  m    registered result
//   o_status  out  4    registered flags {V,N,Z,P} = [3]..[0]
// BEHAVIOUR
//   - One clock domain (i_clk) and one reset. i_rsn is synchronous and active-low:
//     i_rsn=0 at a rising edge -> o_result=0, o_status=4'b0000. Reset overrides all
//     inputs. While i_rsn stays low the outputs stay 0.
//   - Latency is 1 cycle. Inputs sampled at edge k appear on the outputs after edge k.
//     There is no handshake; a new operation is accepted every cycle.
//   - Operations; arithmetic is computed at m+1 bits, and the result is the low m bits
//     (wraps):
//       00 ADD : R = A + B
//       01 SUB : R = A - B
//       10 AND : R = A & B
//       11 XOR : R = A ^ B
//   - Flags are computed from the new R in the same cycle:
//       V [3]: signed overflow. ADD: sign(A)==sign(B) and sign(R)!=sign(A).
//              SUB: sign(A)!=sign(B) and sign(R)!=sign(A). Always 0 for AND/XOR.
//       N [2]: R[m-1]
//       Z [1]: R == 0
//       P [0]: odd parity of R (XOR-reduce of R)
//   - Opcode codes >= 4 (possible only when n > 2): o_result and o_status hold their
//     previous values.
//   - Boundaries: most-negative minus 1 and most-positive plus 1 wrap and set V.
//     A - A always gives Z=1 and V=0.
//   - No latches and no X propagation. Inputs are purely combinational into the
//     output registers.
// TESTING (m=4, n=2; check outputs after the edge)
//   1 Reset: i_rsn=0, oper=00, A=0111, B=0001, one edge -> result 0000, status 0000
//   2 ADD overflow: i_rsn=1, oper=00, A=0111, B=0001 -> result 1000, status 1101
//   3 SUB zero: oper=01, A=0011, B=0011 -> result 0000, status 0010
//   4 SUB overflow: oper=01, A=1000, B=0001 -> result 0111, status 1001
//   5 AND: oper=10, A=1100, B=1010 -> result 1000, status 0101;
//     XOR: oper=11, A=0101, B=0101 -> result 0000, status 0010
//   6 Reset mid-stream: after test 2, i_rsn=0 for one edge -> result 0000,
//     status 0000; release, next op updates normally

Source files
------------

// File: rtl/exe_unit_w1.sv
// rtl/exe_unit_w1.sv - registered signed ALU: ADD/SUB/AND/XOR with {V,N,Z,P} flags
module exe_unit_w1 #(
   parameter int m = 4,
   parameter int n = 2
) (
   input  logic         i_clk,
   input  logic         i_rsn,
   input  logic [n-1:0] i_oper,
   input  logic [m-1:0] i_argA,
   input  logic [m-1:0] i_argB,
   output logic [m-1:0] o_result,
   output logic [3:0]   o_status
);

   logic [m-1:0] r_result;
   logic [3:0]   r_status;
   logic [m-1:0] w_add;
   logic [m-1:0] w_sub;
   logic [m-1:0] w_res;
   logic         w_v;
   logic         w_op_valid;

   // Only codes 0..3 are defined; wider opcodes with any upper bit set hold state.
   generate
      if (n > 2) begin : g_op_wide
         assign w_op_valid = ~|i_oper[n-1:2];
      end else begin : g_op_narrow
         assign w_op_valid = 1'b1;
      end
   endgenerate

   // Low m bits of the m+1-bit sum/difference; overflow is recovered from the signs.
   assign w_add = i_argA + i_argB;
   assign w_sub = i_argA - i_argB;

   always_comb begin
      w_res = '0;
      w_v   = 1'b0;
      case (i_oper[1:0])
         2'b00: begin
            w_res = w_add;
            w_v   = (i_argA[m-1] == i_argB[m-1]) && (w_add[m-1] != i_argA[m-1]);
         end
         2'b01: begin
            w_res = w_sub;
            w_v   = (i_argA[m-1] != i_argB[m-1]) && (w_sub[m-1] != i_argA[m-1]);
         end
         2'b10: w_res = i_argA & i_argB;
         default: w_res = i_argA ^ i_argB;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rsn) begin
         r_result <= '0;
         r_status <= 4'b0000;
      end else if (w_op_valid) begin
         r_result <= w_res;
         r_status <= {w_v, w_res[m-1], (w_res == '0), ^w_res};
      end
   end

   assign o_result = r_result;
   assign o_status = r_status;

endmodule

// File: tb/tb_exe_unit_w1.sv
// tb/tb_exe_unit_w1.sv - randomized self-checking bench for exe_unit_w1
module tb_exe_unit_w1;

   localparam int M = 4;
   localparam int N = 2;

   logic         clk;
   logic         rsn;
   logic [N-1:0] oper;
   logic [M-1:0] arg_a;
   logic [M-1:0] arg_b;
   logic [M-1:0] result;
   logic [3:0]   status;

   int checks;
   int errors;

   logic [M-1:0] exp_result;
   logic [3:0]   exp_status;

   exe_unit_w1 #(.m(M), .n(N)) dut (
      .i_clk    (clk),
      .i_rsn    (rsn),
      .i_oper   (oper),
      .i_argA   (arg_a),
      .i_argB   (arg_b),
      .o_result (result),
      .o_status (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int to_signed(input int v);
      return (v >= (1 << (M - 1))) ? v - (1 << M) : v;
   endfunction

   // Reference: exact integer arithmetic, then wrap to M bits and derive flags.
   task automatic model(input int op, input int a, input int b);
      int full;
      int r;
      int ones;
      bit v;
      v = 1'b0;
      case (op)
         0: begin
            full = to_signed(a) + to_signed(b);
            v = (full > (1 << (M - 1)) - 1) || (full < -(1 << (M - 1)));
            r = full & ((1 << M) - 1);
         end
         1: begin
            full = to_signed(a) - to_signed(b);
            v = (full > (1 << (M - 1)) - 1) || (full < -(1 << (M - 1)));
            r = full & ((1 << M) - 1);
         end
         2: r = a & b;
         default: r = a ^ b;
      endcase
      ones = 0;
      for (int i = 0; i < M; i++) ones += (r >> i) & 1;
      exp_result = M'(r);
      exp_status = {v, ((r >> (M - 1)) & 1) == 1, r == 0, (ones % 2) == 1};
   endtask

   task automatic step(input string tag, input bit rs, input int op, input int a, input int b);
      @(negedge clk);
      rsn   = rs;
      oper  = N'(op);
      arg_a = M'(a);
      arg_b = M'(b);
      @(posedge clk);
      #1;
      if (!rs) begin
         exp_result = '0;
         exp_status = 4'b0000;
      end else begin
         model(op, a, b);
      end
      check({tag, ".result"}, 32'(result), 32'(exp_result));
      check({tag, ".status"}, 32'(status), 32'(exp_status));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rsn = 1'b0; oper = '0; arg_a = '0; arg_b = '0;

      step("reset",      1'b0, 0, 4'b0111, 4'b0001);
      step("reset_hold", 1'b0, 1, 4'b1000, 4'b0001);
      step("add_ovf",    1'b1, 0, 4'b0111, 4'b0001);
      step("mid_reset",  1'b0, 0, 4'b0111, 4'b0001);
      step("post_reset", 1'b1, 0, 4'b0010, 4'b0011);
      step("sub_zero",   1'b1, 1, 4'b0011, 4'b0011);
      step("sub_ovf",    1'b1, 1, 4'b1000, 4'b0001);
      step("and",        1'b1, 2, 4'b1100, 4'b1010);
      step("xor",        1'b1, 3, 4'b0101, 4'b0101);
      step("neg_add",    1'b1, 0, 4'b1000, 4'b1111);

      for (int i = 0; i < (1 << M); i++)
         step("sub_self", 1'b1, 1, i, i);

      for (int i = 0; i < 400; i++)
         step("rand", ($urandom_range(0, 15) != 0), $urandom_range(0, 3),
              $urandom_range(0, (1 << M) - 1), $urandom_range(0, (1 << M) - 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
